systolic_skew_feeder: RTL and testbench

- Transmit-side front end for the 2D systolic PE array.
- Accepts one k-slice per handshake: a column of A (one word per array row) and a row of B (one word per array column).
- Emits diagonally skewed, zero-padded streams onto the array's downward (i_1) and rightward (i_2) inputs.
- Signals `done` once the last product has been accumulated in the far-corner PE, so the result reader can sample `out`.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/skew_line.sv | 25 ++
 rtl/systolic_skew_feeder.sv | 118 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
package systolic_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Extra skew depth beyond lane 0 summed over both edges of the array.
  function automatic int flush_len(input int dim_1, input int dim_2);
    return dim_1 + dim_2 - 2;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth zero-reset delay line; DEPTH registers between d and q.
module skew_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A columns / B rows onto a DIM_1 x DIM_2 systolic array and flags when results are final.
// Optional FEED stall counter output under `define SYSTOLIC_FEEDER_STALL_CNT_EN.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIM_1      = 3,
  parameter int DIM_2      = 3,
  parameter int K_WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [K_WIDTH-1:0]          k_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*DIM_1-1:0] a_col,
  input  logic [DATA_WIDTH*DIM_2-1:0] b_row,
  output logic [DATA_WIDTH*DIM_2-1:0] o_1,
  output logic [DATA_WIDTH*DIM_1-1:0] o_2,
  output logic                        busy,
  output logic                        done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  // done rises DIM_1+DIM_2 edges after the last handshake, one edge after the
  // corner PE has taken its final product.
  localparam int FLUSH_LAST = flush_len(DIM_1, DIM_2) + 1;
  localparam int FW         = $clog2(FLUSH_LAST + 1);

  state_t             state;
  logic [K_WIDTH-1:0] k_reg;
  logic [K_WIDTH-1:0] acc_cnt;
  logic [FW-1:0]      flush_cnt;
  logic               hs;

  assign in_ready = (state == FEED);
  assign busy     = (state != IDLE);
  assign hs       = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_reg     <= '0;
      acc_cnt   <= '0;
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              state   <= FEED;
              k_reg   <= k_len;
              acc_cnt <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FEED: begin
          if (hs) begin
            acc_cnt <= acc_cnt + K_WIDTH'(1);
            if (acc_cnt == k_reg - K_WIDTH'(1)) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(FLUSH_LAST)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == FEED && !in_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  // Non-accepted cycles inject zeros so bubbles add nothing downstream.
  for (genvar r = 0; r < DIM_1; r++) begin : g_row
    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(r + 1)) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (hs ? a_col[(r+1)*DATA_WIDTH-1 -: DATA_WIDTH] : '0),
      .q     (o_2[(r+1)*DATA_WIDTH-1 -: DATA_WIDTH])
    );
  end

  for (genvar c = 0; c < DIM_2; c++) begin : g_col
    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(c + 1)) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (hs ? b_row[(c+1)*DATA_WIDTH-1 -: DATA_WIDTH] : '0),
      .q     (o_1[(c+1)*DATA_WIDTH-1 -: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a behavioural 3x3 output-stationary array.
module tb_systolic_skew_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  k_len;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] a_col;
  logic [47:0] b_row;
  logic [47:0] o_1;
  logic [47:0] o_2;
  logic        busy;
  logic        done;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  systolic_skew_feeder #(.DATA_WIDTH(16), .DIM_1(3), .DIM_2(3), .K_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .o_1       (o_1),
    .o_2       (o_2),
    .busy      (busy),
    .done      (done)
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE array: a flows right, b flows down, each PE registers both.
  logic [15:0] a_reg [3][3];
  logic [15:0] b_reg [3][3];
  int          acc   [3][3];
  logic        arr_clr = 1'b0;

  always @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic [15:0] ia, ib;
        ia = (c == 0) ? o_2[r*16 +: 16] : a_reg[r][(c == 0) ? 0 : c-1];
        ib = (r == 0) ? o_1[c*16 +: 16] : b_reg[(r == 0) ? 0 : r-1][c];
        if (arr_clr) begin
          a_reg[r][c] <= '0;
          b_reg[r][c] <= '0;
          acc[r][c]   <= 0;
        end else begin
          a_reg[r][c] <= ia;
          b_reg[r][c] <= ib;
          acc[r][c]   <= acc[r][c] + int'(ia) * int'(ib);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int a_val(input int r, input int k);
    return 3 * r + k + 1;
  endfunction

  typedef struct {
    logic [47:0] a;
    logic [47:0] b;
    int          lat;
  } vec_t;

  vec_t vecs[4];

  // A = [[1,2,3],[4,5,6],[7,8,9]], B = I, k_len = 3; result must equal A.
  task automatic run_mat(input string nm, input logic [4:0] mask, input int slots,
                         input bit start_mid, input int exp_lat);
    int k, lat, ndone, first;
    arr_clr = 1'b1;
    start   = 1'b1;
    k_len   = 8'd3;
    @(negedge clk);
    start   = 1'b0;
    arr_clr = 1'b0;
    k = 0; lat = 0; ndone = 0; first = -1;
    for (int i = 0; i < slots; i++) begin
      chk({nm, "_rdy_feed"}, 64'(in_ready), 64'd1);
      start    = start_mid && (i == 1);
      k_len    = start_mid ? 8'd1 : 8'd3;
      in_valid = mask[i];
      a_col    = '0;
      b_row    = '0;
      if (mask[i]) begin
        for (int r = 0; r < 3; r++) a_col[r*16 +: 16] = 16'(a_val(r, k));
        b_row[k*16 +: 16] = 16'd1;
        k++;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0; in_valid = 1'b0; a_col = '0; b_row = '0; k_len = 8'd0;
    chk({nm, "_rdy_flush"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = lat;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              chk($sformatf("%s_out_%0d_%0d", nm, r, c), 64'(acc[r][c]), 64'(a_val(r, c)));
        end
      end
      @(negedge clk);
      lat++;
    end
    chk({nm, "_done_lat"}, 64'(first), 64'(exp_lat));
    chk({nm, "_done_cnt"}, 64'(ndone), 64'd1);
    chk({nm, "_idle"}, 64'({busy, in_ready}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; a_col = '0; b_row = '0;

    vecs[0] = '{a: {16'd3, 16'd2, 16'd1},          b: {16'd6, 16'd5, 16'd4},          lat: 6};
    vecs[1] = '{a: {16'hFFFF, 16'h8000, 16'h0001}, b: {16'h1234, 16'hABCD, 16'h0000}, lat: 6};
    vecs[2] = '{a: {16'h0000, 16'h5A5A, 16'h0000}, b: {16'h0001, 16'h0000, 16'hFFFF}, lat: 6};
    vecs[3] = '{a: {16'h00F0, 16'h0F00, 16'hF000}, b: {16'h7FFF, 16'h0002, 16'h0003}, lat: 6};

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("in_reset", 64'({o_1, o_2, in_ready, busy, done}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_%0d", i), 64'({o_1, o_2, in_ready, busy, done}), 64'd0);
    end

    // Single-slice skew: lane r shows its word only j==r cycles after the handshake
    foreach (vecs[v]) begin
      start = 1'b1; k_len = 8'd1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_rdy", v), 64'({busy, in_ready}), 64'h3);
      in_valid = 1'b1; a_col = vecs[v].a; b_row = vecs[v].b;
      @(negedge clk);
      in_valid = 1'b0; a_col = '0; b_row = '0;
      for (int j = 0; j < 8; j++) begin
        logic [47:0] e2, e1;
        e2 = '0; e1 = '0;
        if (j < 3) begin
          e2[j*16 +: 16] = vecs[v].a[j*16 +: 16];
          e1[j*16 +: 16] = vecs[v].b[j*16 +: 16];
        end
        chk($sformatf("v%0d_o2_c%0d", v, j), 64'(o_2), 64'(e2));
        chk($sformatf("v%0d_o1_c%0d", v, j), 64'(o_1), 64'(e1));
        chk($sformatf("v%0d_done_c%0d", v, j), 64'(done), 64'(j == vecs[v].lat));
        @(negedge clk);
      end
    end

    // Full matmul, continuous and with bubbles (two stalls delay done by two cycles)
    run_mat("cont", 5'b00111, 3, 1'b0, 9);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("stall_cont", 64'(stall_cnt), 64'd0);
`endif
    run_mat("bubble", 5'b10101, 5, 1'b0, 11);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    chk("stall_bubble", 64'(stall_cnt), 64'd2);
`endif
    run_mat("start_in_feed", 5'b00111, 3, 1'b1, 9);

    // k_len == 0: immediate done, never ready
    start = 1'b1; k_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("k0_done", 64'({done, in_ready, busy}), 64'h4);
    @(negedge clk);
    chk("k0_after", 64'({done, in_ready, busy}), 64'h0);

    // Reset two cycles into FLUSH
    start = 1'b1; k_len = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_col = vecs[0].a; b_row = vecs[0].b;
    @(negedge clk);
    in_valid = 1'b0; a_col = '0; b_row = '0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({o_1, o_2, in_ready, busy, done}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      chk($sformatf("rst_no_done_%0d", i), 64'({done, busy, in_ready}), 64'd0);
    end
    run_mat("after_rst", 5'b00111, 3, 1'b0, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
